// File: rtl/pslip_grant_arb.sv
// Priority-aware round-robin grant arbiter for one pSLIP output port.
// Max priority is found by an MSB-first bit-serial scan over per-port candidate lanes.

module pslip_grant_arb_lane #(
    parameter int C  = 4,
    parameter int BW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          scan,
    input  logic [BW-1:0] bsel,
    input  logic          any_hit,
    input  logic [C-1:0]  pri_in,
    output logic [C-1:0]  pri_q,
    output logic          cand,
    output logic          hit
);
    assign hit = cand & pri_q[bsel];

    // A candidate drops out only when some other candidate has a 1 in this bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pri_q <= '0;
            cand  <= 1'b0;
        end else if (load) begin
            pri_q <= pri_in;
            cand  <= |pri_in;
        end else if (scan && any_hit && !pri_q[bsel]) begin
            cand  <= 1'b0;
        end
    end
endmodule

module pslip_grant_arb #(
    parameter int N  = 16,
    parameter int C  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                first_iter,
    input  logic [N-1:0][C-1:0] req_pri,
    input  logic                resp_valid,
    input  logic                resp_accept,
    output logic [N-1:0]        gnt,
    output logic [PW-1:0]       gnt_idx,
    output logic [C-1:0]        gnt_pri,
    output logic                gnt_valid,
    output logic                done,
    output logic                busy,
    output logic [PW-1:0]       ptr
);
    localparam int KW = (C > 1) ? $clog2(C) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_PICK  = 2'd2;
    localparam logic [1:0] S_GRANT = 2'd3;

    logic [1:0]          state;
    logic [KW-1:0]       k;
    logic                fi_q;
    logic [KW-1:0]       bsel;
    logic [N-1:0]        cand, hit;
    logic [N-1:0][C-1:0] pri_all;
    logic                any_hit, load, scan;
    logic                win_found;
    logic [PW-1:0]       win_idx;

    assign bsel    = KW'(C-1) - k;
    assign any_hit = |hit;
    assign load    = (state == S_IDLE) && start;
    assign scan    = (state == S_SCAN);
    assign busy    = (state != S_IDLE);

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        pslip_grant_arb_lane #(.C(C), .BW(KW)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load    (load),
            .scan    (scan),
            .bsel    (bsel),
            .any_hit (any_hit),
            .pri_in  (req_pri[gi]),
            .pri_q   (pri_all[gi]),
            .cand    (cand[gi]),
            .hit     (hit[gi])
        );
    end

    // Explicit wrap so the cyclic search stays correct when N is not a power of 2.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int j);
        int s;
        s = int'(p) + j;
        if (s >= N) s = s - N;
        return PW'(s);
    endfunction

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int j = 0; j < N; j++) begin
            if (!win_found && cand[wrap_add(ptr, j)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(ptr, j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            k         <= '0;
            fi_q      <= 1'b0;
            ptr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_pri   <= '0;
            gnt_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    fi_q  <= first_iter;
                    k     <= '0;
                    state <= S_SCAN;
                end
                S_SCAN: begin
                    k <= k + KW'(1);
                    if (k == KW'(C-1)) state <= S_PICK;
                end
                S_PICK: if (win_found) begin
                    gnt          <= '0;
                    gnt[win_idx] <= 1'b1;
                    gnt_idx      <= win_idx;
                    gnt_pri      <= pri_all[win_idx];
                    gnt_valid    <= 1'b1;
                    state        <= S_GRANT;
                end else begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: if (resp_valid) begin
                    if (resp_accept && fi_q)
                        ptr <= (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);
                    gnt       <= '0;
                    gnt_idx   <= '0;
                    gnt_pri   <= '0;
                    gnt_valid <= 1'b0;
                    done      <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pslip_grant_arb.sv
// Bench for pslip_grant_arb: directed table of rounds, reset corners, then random rounds vs a max/cyclic-search model.

module tb_pslip_grant_arb;
    localparam int N  = 16;
    localparam int C  = 4;
    localparam int PW = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic                first_iter = 1'b0;
    logic [N-1:0][C-1:0] req_pri = '0;
    logic                resp_valid = 1'b0;
    logic                resp_accept = 1'b0;
    logic [N-1:0]        gnt;
    logic [PW-1:0]       gnt_idx;
    logic [C-1:0]        gnt_pri;
    logic                gnt_valid, done, busy;
    logic [PW-1:0]       ptr;

    pslip_grant_arb #(.N(N), .C(C)) dut (
        .clk(clk), .reset(reset), .start(start), .first_iter(first_iter),
        .req_pri(req_pri), .resp_valid(resp_valid), .resp_accept(resp_accept),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_pri(gnt_pri), .gnt_valid(gnt_valid),
        .done(done), .busy(busy), .ptr(ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*C-1:0] req;
        bit             fi;
        bit             acc;
        int             rdly;
        bit             empty;
        int             idx;
        int             pri;
        int             ptr_after;
    } vec_t;

    vec_t tbl[11];
    int   n_chk = 0;
    int   n_pass = 0;
    int   ptr_m = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, exp);
    endtask

    function automatic logic [N*C-1:0] setp(input logic [N*C-1:0] r, input int i, input int p);
        logic [N*C-1:0] o;
        o = r;
        o[i*C +: C] = C'(p);
        return o;
    endfunction

    // Reference: highest nonzero priority wins; ties go to the first port at/after ptr, cyclically.
    function automatic void model(input logic [N*C-1:0] r, input int p, output int win, output int mp);
        mp  = 0;
        win = -1;
        for (int i = 0; i < N; i++) if (int'(r[i*C +: C]) > mp) mp = int'(r[i*C +: C]);
        if (mp != 0)
            for (int j = N - 1; j >= 0; j--)
                if (int'(r[((p + j) % N)*C +: C]) == mp) win = (p + j) % N;
    endfunction

    task automatic run_round(input logic [N*C-1:0] r, input bit fi, input bit acc, input int rdly,
                             input bit empty, input int eidx, input int epri, input int eptr, input string tag);
        logic [N-1:0] eg;
        req_pri = r; first_iter = fi; start = 1'b1;
        tick;                                   // cycle 1
        start = 1'b0; req_pri = {$urandom, $urandom}; first_iter = ~fi;
        check({tag, " busy scan"}, 64'(busy), 64'd1);
        tick; tick;                             // cycle 3: stray start during SCAN
        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;                             // cycle 6
        if (empty) begin
            check({tag, " empty done"}, 64'(done), 64'd1);
            check({tag, " empty gnt_valid"}, 64'(gnt_valid), 64'd0);
            check({tag, " empty busy"}, 64'(busy), 64'd0);
            check({tag, " empty ptr"}, 64'(ptr), 64'(eptr));
            return;
        end
        eg = '0; eg[eidx] = 1'b1;
        check({tag, " gnt_valid"}, 64'(gnt_valid), 64'd1);
        check({tag, " gnt"}, 64'(gnt), 64'(eg));
        check({tag, " gnt_idx"}, 64'(gnt_idx), 64'(eidx));
        check({tag, " gnt_pri"}, 64'(gnt_pri), 64'(epri));
        for (int d = 0; d < rdly; d++) begin
            start = (d == 0);
            tick;
            start = 1'b0;
        end
        if (rdly > 0) check({tag, " gnt held"}, 64'(gnt_valid), 64'd1);
        resp_valid = 1'b1; resp_accept = acc;
        tick;
        resp_valid = 1'b0; resp_accept = 1'b0;
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " gnt_valid clr"}, 64'(gnt_valid), 64'd0);
        check({tag, " gnt clr"}, 64'({gnt, gnt_idx, gnt_pri}), 64'd0);
        check({tag, " busy idle"}, 64'(busy), 64'd0);
        check({tag, " ptr"}, 64'(ptr), 64'(eptr));
    endtask

    task automatic reset_check(input string tag);
        check({tag, " gnt"}, 64'(gnt), 64'd0);
        check({tag, " idx/pri"}, 64'({gnt_idx, gnt_pri}), 64'd0);
        check({tag, " valid/done/busy"}, 64'({gnt_valid, done, busy}), 64'd0);
        check({tag, " ptr"}, 64'(ptr), 64'd0);
    endtask

    initial begin
        logic [N*C-1:0] r, r3, r7, rw;
        int win, mp, lim, eptr;
        bit fi, acc;

        r = '0;
        r3 = setp(setp(setp('0, 2, 9), 7, 12), 11, 12);
        r7 = setp('0, 7, 4);
        rw = setp(setp('0, 15, 7), 0, 7);
        tbl[0]  = '{setp('0, 5, 3),  1, 1, 2, 0, 5,  3,  6};
        tbl[1]  = '{r3,              1, 1, 0, 0, 7,  12, 8};
        tbl[2]  = '{r3,              1, 1, 1, 0, 11, 12, 12};
        tbl[3]  = '{r3,              1, 1, 3, 0, 7,  12, 8};
        tbl[4]  = '{setp('0, 5, 1),  1, 1, 0, 0, 5,  1,  6};
        tbl[5]  = '{r7,              1, 0, 1, 0, 7,  4,  6};
        tbl[6]  = '{r7,              0, 1, 2, 0, 7,  4,  6};
        tbl[7]  = '{'0,              1, 1, 0, 1, 0,  0,  6};
        tbl[8]  = '{setp('0, 14, 5), 1, 1, 0, 0, 14, 5,  15};
        tbl[9]  = '{rw,              1, 1, 1, 0, 15, 7,  0};
        tbl[10] = '{rw,              1, 1, 0, 0, 0,  7,  1};

        reset = 1'b0;
        repeat (3) tick;
        reset = 1'b1;
        tick;
        reset_check("reset");

        for (int i = 0; i < 11; i++)
            run_round(tbl[i].req, tbl[i].fi, tbl[i].acc, tbl[i].rdly, tbl[i].empty,
                      tbl[i].idx, tbl[i].pri, tbl[i].ptr_after, $sformatf("vec%0d", i));

        resp_valid = 1'b1; resp_accept = 1'b1;
        tick; tick;
        resp_valid = 1'b0; resp_accept = 1'b0;
        check("idle resp ptr", 64'(ptr), 64'd1);
        check("idle resp busy", 64'({busy, done, gnt_valid}), 64'd0);

        // reset in the middle of SCAN
        req_pri = setp('0, 3, 2); first_iter = 1'b1; start = 1'b1;
        tick; start = 1'b0; tick;
        reset = 1'b0; tick; reset = 1'b1;
        reset_check("rst scan");

        // move ptr off zero, then reset while holding a grant
        run_round(setp('0, 9, 2), 1, 1, 0, 0, 9, 2, 10, "pre grant");
        req_pri = setp('0, 3, 1); first_iter = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        repeat (6) tick;
        check("mid grant valid", 64'(gnt_valid), 64'd1);
        reset = 1'b0; tick; reset = 1'b1;
        reset_check("rst grant");

        ptr_m = 0;
        for (int t = 0; t < 60; t++) begin
            lim = ($urandom_range(0, 1) == 0) ? 3 : 15;
            r = '0;
            if (t % 9 != 4)
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 2) == 0) r = setp(r, i, int'($urandom_range(1, lim)));
            fi  = $urandom_range(0, 3) != 0;
            acc = $urandom_range(0, 3) != 0;
            model(r, ptr_m, win, mp);
            eptr = ptr_m;
            if (mp != 0 && fi && acc) eptr = (win + 1) % N;
            run_round(r, fi, acc, int'($urandom_range(0, 3)), mp == 0,
                      (win < 0) ? 0 : win, mp, eptr, $sformatf("rnd%0d", t));
            ptr_m = eptr;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
